// File: rtl/window_gen_3x3.sv
// Streaming 3x3 window generator: two line buffers feed a 3x3 register window,
// and only windows lying fully inside the image are presented, one cycle after the pixel.
module window_gen_3x3 #(
    parameter int DATA_WIDHT = 32,
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDHT-1:0] Data_In,
    input  logic                  Valid_In,
    output logic [DATA_WIDHT-1:0] Data_Out0,
    output logic [DATA_WIDHT-1:0] Data_Out1,
    output logic [DATA_WIDHT-1:0] Data_Out2,
    output logic [DATA_WIDHT-1:0] Data_Out3,
    output logic [DATA_WIDHT-1:0] Data_Out4,
    output logic [DATA_WIDHT-1:0] Data_Out5,
    output logic [DATA_WIDHT-1:0] Data_Out6,
    output logic [DATA_WIDHT-1:0] Data_Out7,
    output logic [DATA_WIDHT-1:0] Data_Out8,
    output logic                  Valid_Out,
    output logic                  Frame_Done
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic [DATA_WIDHT-1:0] lb0 [IMG_WIDTH];
    logic [DATA_WIDHT-1:0] lb1 [IMG_WIDTH];
    logic [DATA_WIDHT-1:0] win [9];
    logic [DATA_WIDHT-1:0] dout [9];
    logic                  col_last;
    logic                  row_last;
    logic                  in_window;
    logic                  win_valid;
    logic                  win_last;

    assign col_last  = (col == CW'(IMG_WIDTH - 1));
    assign row_last  = (row == RW'(IMG_HEIGHT - 1));
    assign in_window = (row >= RW'(2)) && (col >= CW'(2));

    // Line buffers carry no reset; stale contents are masked by the valid gating.
    always_ff @(posedge clk) begin
        if (Valid_In && !rst) begin
            lb1[col] <= lb0[col];
            lb0[col] <= Data_In;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            win_valid  <= 1'b0;
            win_last   <= 1'b0;
            Valid_Out  <= 1'b0;
            Frame_Done <= 1'b0;
            for (int unsigned i = 0; i < 9; i++) begin
                win[i]  <= '0;
                dout[i] <= '0;
            end
        end else begin
            win_valid <= Valid_In && in_window;
            win_last  <= Valid_In && in_window && col_last && row_last;
            if (Valid_In) begin
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
                win[0] <= win[1];
                win[1] <= win[2];
                win[2] <= lb1[col];
                win[3] <= win[4];
                win[4] <= win[5];
                win[5] <= lb0[col];
                win[6] <= win[7];
                win[7] <= win[8];
                win[8] <= Data_In;
            end
            // Second stage: snapshot the window built on the previous accepted pixel.
            Valid_Out  <= win_valid;
            Frame_Done <= win_last;
            if (win_valid) begin
                for (int unsigned i = 0; i < 9; i++) begin
                    dout[i] <= win[i];
                end
            end
        end
    end

    assign Data_Out0 = dout[0];
    assign Data_Out1 = dout[1];
    assign Data_Out2 = dout[2];
    assign Data_Out3 = dout[3];
    assign Data_Out4 = dout[4];
    assign Data_Out5 = dout[5];
    assign Data_Out6 = dout[6];
    assign Data_Out7 = dout[7];
    assign Data_Out8 = dout[8];

endmodule

// File: tb/tb_window_gen_3x3.sv
// Directed bench for window_gen_3x3: a 4x4 instance for window sequencing and an
// 8x8 instance fed with float pixel values.
module tb_window_gen_3x3;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] din;
    logic        vin;
    logic [31:0] d0, d1, d2, d3, d4, d5, d6, d7, d8;
    logic        vout, fdone;

    logic [31:0] din8;
    logic        vin8;
    logic [31:0] e0, e1, e2, e3, e4, e5, e6, e7, e8;
    logic        vout8, fdone8;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [8:0][31:0] w;
        logic             fd;
    } rec_t;
    rec_t cap_q[$];
    int   bad_gate = 0;
    int   fd_stray = 0;
    logic acc_now;
    logic last_acc = 1'b0;

    logic [31:0] exp4 [4][9] = '{
        '{32'd1, 32'd2, 32'd3, 32'd5, 32'd6, 32'd7, 32'd9,  32'd10, 32'd11},
        '{32'd2, 32'd3, 32'd4, 32'd6, 32'd7, 32'd8, 32'd10, 32'd11, 32'd12},
        '{32'd5, 32'd6, 32'd7, 32'd9, 32'd10, 32'd11, 32'd13, 32'd14, 32'd15},
        '{32'd6, 32'd7, 32'd8, 32'd10, 32'd11, 32'd12, 32'd14, 32'd15, 32'd16}
    };
    logic [31:0] exp8_first [9] = '{
        32'h3F800000, 32'h40000000, 32'h40400000,
        32'h41100000, 32'h41200000, 32'h41300000,
        32'h41880000, 32'h41900000, 32'h41980000
    };

    always #5 clk = ~clk;

    window_gen_3x3 #(.DATA_WIDHT(32), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut (
        .clk(clk), .rst(rst), .Data_In(din), .Valid_In(vin),
        .Data_Out0(d0), .Data_Out1(d1), .Data_Out2(d2),
        .Data_Out3(d3), .Data_Out4(d4), .Data_Out5(d5),
        .Data_Out6(d6), .Data_Out7(d7), .Data_Out8(d8),
        .Valid_Out(vout), .Frame_Done(fdone)
    );

    window_gen_3x3 #(.DATA_WIDHT(32), .IMG_WIDTH(8), .IMG_HEIGHT(8)) dut8 (
        .clk(clk), .rst(rst), .Data_In(din8), .Valid_In(vin8),
        .Data_Out0(e0), .Data_Out1(e1), .Data_Out2(e2),
        .Data_Out3(e3), .Data_Out4(e4), .Data_Out5(e5),
        .Data_Out6(e6), .Data_Out7(e7), .Data_Out8(e8),
        .Valid_Out(vout8), .Frame_Done(fdone8)
    );

    // Capture every presented window of the 4x4 instance and flag pulses without a prior accept.
    always @(posedge clk) begin
        rec_t r;
        acc_now = vin && !rst;
        #1;
        if (vout) begin
            if (!last_acc) bad_gate++;
            r.w  = {d8, d7, d6, d5, d4, d3, d2, d1, d0};
            r.fd = fdone;
            cap_q.push_back(r);
        end else if (fdone) begin
            fd_stray++;
        end
        last_acc = acc_now;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [31:0] d);
        @(negedge clk);
        rst = r;
        vin = v;
        din = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'hDEAD0000 + 32'(i));
    endtask

    task automatic check_frame(input string tag, input logic [31:0] off);
        rec_t r;
        for (int k = 0; k < 4; k++) begin
            if (cap_q.size() == 0) begin
                chk({tag, "_missing"}, 32'(k), 32'd4);
                return;
            end
            r = cap_q.pop_front();
            for (int j = 0; j < 9; j++)
                chk($sformatf("%s_w%0d_d%0d", tag, k, j), r.w[j], exp4[k][j] + off);
            chk($sformatf("%s_w%0d_fd", tag, k), 32'(r.fd), (k == 3) ? 32'd1 : 32'd0);
        end
    endtask

    function automatic logic [31:0] f32(input int unsigned n);
        int unsigned e = 0;
        for (int unsigned i = 0; i < 32; i++)
            if ((n >> i) != 0) e = i;
        return {1'b0, 8'(127 + e), 23'((n << (23 - e)) & 32'h007FFFFF)};
    endfunction

    initial begin
        int          cnt8;
        int          fd8;
        int          fd_at;
        int          n;
        logic [31:0] first8 [9];

        rst  = 1'b1;
        vin  = 1'b0;
        din  = '0;
        vin8 = 1'b0;
        din8 = '0;

        // Reset held with traffic: everything stays zero.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, (i % 2 == 1) ? 32'hFFFFFFFF : 32'h12345678 ^ 32'(i));
            if (i >= 1) begin
                chk("rst_vout", 32'(vout), 32'd0);
                chk("rst_fd", 32'(fdone), 32'd0);
                chk("rst_data", d0 | d1 | d2 | d3 | d4 | d5 | d6 | d7 | d8, 32'd0);
            end
        end
        step(1'b0, 1'b0, 32'd0);
        cap_q.delete();

        // Continuous 4x4 frame, with latency checks around pixel 11.
        for (int p = 1; p <= 16; p++) begin
            step(1'b0, 1'b1, 32'(p));
            if (p == 12) chk("lat_early", 32'(vout), 32'd0);
            if (p == 13) begin
                chk("lat_vout", 32'(vout), 32'd1);
                chk("lat_d8", d8, 32'd11);
                chk("lat_d0", d0, 32'd1);
            end
        end
        idle(3);
        chk("t1_count", 32'(cap_q.size()), 32'd4);
        check_frame("t1", 32'd0);

        // Same frame with bubbles: 1,0,0,1 then random gaps carrying junk data.
        cap_q.delete();
        for (int p = 1; p <= 16; p++) begin
            step(1'b0, 1'b1, 32'(p));
            n = (p == 1) ? 2 : int'($urandom_range(0, 2));
            for (int b = 0; b < n; b++) step(1'b0, 1'b0, $urandom);
        end
        idle(3);
        chk("t2_count", 32'(cap_q.size()), 32'd4);
        check_frame("t2", 32'd0);

        // Two back-to-back frames.
        cap_q.delete();
        for (int p = 1; p <= 16; p++) step(1'b0, 1'b1, 32'(p));
        for (int p = 1; p <= 16; p++) step(1'b0, 1'b1, 32'(100 + p));
        idle(3);
        chk("t3_count", 32'(cap_q.size()), 32'd8);
        check_frame("t3a", 32'd0);
        check_frame("t3b", 32'd100);

        // Reset after pixel 7, then a fresh frame.
        cap_q.delete();
        for (int p = 1; p <= 7; p++) step(1'b0, 1'b1, 32'(p));
        step(1'b1, 1'b0, 32'd0);
        for (int p = 1; p <= 16; p++) step(1'b0, 1'b1, 32'(p));
        idle(3);
        chk("t4_count", 32'(cap_q.size()), 32'd4);
        check_frame("t4", 32'd0);

        chk("gate_violation", 32'(bad_gate), 32'd0);
        chk("fd_stray", 32'(fd_stray), 32'd0);

        // 8x8 instance with float pixels 1.0 .. 64.0.
        cnt8  = 0;
        fd8   = 0;
        fd_at = 0;
        for (int k = 0; k < 9; k++) first8[k] = '0;
        for (int i = 0; i < 67; i++) begin
            @(negedge clk);
            if (vout8) begin
                cnt8++;
                if (cnt8 == 1) first8 = '{e0, e1, e2, e3, e4, e5, e6, e7, e8};
            end
            if (fdone8) begin
                fd8++;
                fd_at = cnt8;
            end
            vin8 = (i < 64);
            din8 = f32(32'(i + 1));
        end
        chk("t5_count", 32'(cnt8), 32'd36);
        chk("t5_fd_count", 32'(fd8), 32'd1);
        chk("t5_fd_pos", 32'(fd_at), 32'd36);
        for (int j = 0; j < 9; j++)
            chk($sformatf("t5_first_d%0d", j), first8[j], exp8_first[j]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
